// File: rtl/pong_engine.sv
// Two-player pong game core: self-timed update tick, paddle and ball physics,
// scoring and the IDLE/SERVE/PLAY/GAMEOVER control flow.
module pong_engine #(
    parameter int H_RES        = 1280,
    parameter int V_RES        = 1024,
    parameter int BORDER       = 100,
    parameter int PADDLE_H     = 150,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_X     = 150,
    parameter int BALL_R       = 10,
    parameter int TICK_DIV     = 131072,
    parameter int PADDLE_STEP  = 2,
    parameter int SPEED_INIT   = 1,
    parameter int SPEED_MAX    = 4,
    parameter int SPEEDUP_HITS = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_TICKS  = 128
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        newGame,
    input  logic        pause,
    input  logic        keyUpL,
    input  logic        keyDnL,
    input  logic        keyUpR,
    input  logic        keyDnR,
    output logic [10:0] xBall,
    output logic [10:0] yBall,
    output logic [10:0] yPL,
    output logic [10:0] yPR,
    output logic [3:0]  scoreL,
    output logic [3:0]  scoreR,
    output logic [1:0]  state,
    output logic        gameOver,
    output logic        winner,
    output logic        pointL,
    output logic        pointR
);

    typedef logic signed [11:0] coord_t;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StServe    = 2'd1,
        StPlay     = 2'd2,
        StGameOver = 2'd3
    } pongState_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SERVE_TICKS + 1);
    localparam int HW = $clog2(SPEEDUP_HITS + 1);

    localparam coord_t X_MID    = coord_t'(H_RES / 2);
    localparam coord_t Y_MID    = coord_t'(V_RES / 2);
    localparam coord_t PAD_INIT = coord_t'(V_RES / 2 - PADDLE_H / 2);
    localparam coord_t PAD_MIN  = coord_t'(BORDER);
    localparam coord_t PAD_MAX  = coord_t'(V_RES - BORDER - PADDLE_H);
    localparam coord_t WALL_TOP = coord_t'(BORDER);
    localparam coord_t WALL_BOT = coord_t'(V_RES - BORDER);
    localparam coord_t WALL_LFT = coord_t'(BORDER);
    localparam coord_t WALL_RGT = coord_t'(H_RES - BORDER);
    localparam coord_t FACE_L   = coord_t'(PADDLE_X);
    localparam coord_t FACE_R   = coord_t'(H_RES - PADDLE_X);
    localparam coord_t RAD      = coord_t'(BALL_R);
    localparam coord_t PW       = coord_t'(PADDLE_W);
    localparam coord_t PH       = coord_t'(PADDLE_H);
    localparam coord_t PSTEP    = coord_t'(PADDLE_STEP);

    localparam logic [3:0]    SPD_INIT  = 4'(SPEED_INIT);
    localparam logic [3:0]    SPD_MAX   = 4'(SPEED_MAX);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SERVE_END = SW'(SERVE_TICKS - 1);
    localparam logic [HW-1:0] HIT_LAST  = HW'(SPEEDUP_HITS - 1);

    pongState_t    stateQ, stateD;
    logic [TW-1:0] tickCntQ;
    logic [10:0]   xBallQ, xBallD, yBallQ, yBallD;
    logic [10:0]   yPLQ, yPLD, yPRQ, yPRD;
    logic          dirRightQ, dirRightD, dirDownQ, dirDownD;
    logic [3:0]    speedQ, speedD;
    logic [HW-1:0] hitCntQ, hitCntD;
    logic [SW-1:0] serveCntQ, serveCntD;
    logic [3:0]    scoreLQ, scoreLD, scoreRQ, scoreRD;
    logic          winnerQ, winnerD;
    logic          pointLQ, pointLD, pointRQ, pointRD;

    logic   upd;
    coord_t xCur, yCur, plCur, prCur, spd, nx, ny;
    logic   inRangeL, inRangeR, hitL, hitR;

    // Keys are active-low; both or neither pressed holds the paddle.
    function automatic coord_t movePaddle(coord_t y, logic upN, logic dnN);
        coord_t n;
        n = y;
        if (!upN && dnN) begin
            n = y - PSTEP;
        end else if (upN && !dnN) begin
            n = y + PSTEP;
        end
        if (n < PAD_MIN) begin
            n = PAD_MIN;
        end else if (n > PAD_MAX) begin
            n = PAD_MAX;
        end
        return n;
    endfunction

    assign upd   = (tickCntQ == TICK_LAST) && !pause;
    assign xCur  = coord_t'({1'b0, xBallQ});
    assign yCur  = coord_t'({1'b0, yBallQ});
    assign plCur = coord_t'({1'b0, yPLQ});
    assign prCur = coord_t'({1'b0, yPRQ});
    assign spd   = coord_t'(speedQ);

    assign inRangeL = (yCur >= plCur - RAD) && (yCur <= plCur + PH + RAD);
    assign inRangeR = (yCur >= prCur - RAD) && (yCur <= prCur + PH + RAD);

    always_comb begin
        stateD    = stateQ;
        xBallD    = xBallQ;
        yBallD    = yBallQ;
        yPLD      = yPLQ;
        yPRD      = yPRQ;
        dirRightD = dirRightQ;
        dirDownD  = dirDownQ;
        speedD    = speedQ;
        hitCntD   = hitCntQ;
        serveCntD = serveCntQ;
        scoreLD   = scoreLQ;
        scoreRD   = scoreRQ;
        winnerD   = winnerQ;
        pointLD   = 1'b0;
        pointRD   = 1'b0;
        nx        = xCur;
        ny        = yCur;
        hitL      = 1'b0;
        hitR      = 1'b0;

        if (newGame) begin
            stateD    = StServe;
            xBallD    = 11'(X_MID);
            yBallD    = 11'(Y_MID);
            yPLD      = 11'(PAD_INIT);
            yPRD      = 11'(PAD_INIT);
            dirRightD = 1'b1;
            dirDownD  = 1'b1;
            speedD    = SPD_INIT;
            hitCntD   = '0;
            serveCntD = '0;
            scoreLD   = '0;
            scoreRD   = '0;
            winnerD   = 1'b0;
        end else if (upd) begin
            case (stateQ)
                StServe: begin
                    yPLD   = 11'(movePaddle(plCur, keyUpL, keyDnL));
                    yPRD   = 11'(movePaddle(prCur, keyUpR, keyDnR));
                    xBallD = 11'(X_MID);
                    yBallD = 11'(Y_MID);
                    if (serveCntQ == SERVE_END) begin
                        stateD    = StPlay;
                        serveCntD = '0;
                    end else begin
                        serveCntD = serveCntQ + 1'b1;
                    end
                end
                StPlay: begin
                    yPLD = 11'(movePaddle(plCur, keyUpL, keyDnL));
                    yPRD = 11'(movePaddle(prCur, keyUpR, keyDnR));
                    nx   = dirRightQ ? xCur + spd : xCur - spd;
                    ny   = dirDownQ ? yCur + spd : yCur - spd;

                    if (!dirDownQ && (ny - RAD <= WALL_TOP)) begin
                        ny       = WALL_TOP + RAD;
                        dirDownD = 1'b1;
                    end else if (dirDownQ && (ny + RAD >= WALL_BOT)) begin
                        ny       = WALL_BOT - RAD;
                        dirDownD = 1'b0;
                    end

                    // A ball already deep behind a face can no longer be returned.
                    hitL = !dirRightQ && (nx - RAD <= FACE_L) &&
                           (xCur - RAD >= FACE_L - PW) && inRangeL;
                    hitR = dirRightQ && (nx + RAD >= FACE_R) &&
                           (xCur + RAD <= FACE_R + PW) && inRangeR;

                    if (hitL || hitR) begin
                        nx        = hitL ? FACE_L + RAD : FACE_R - RAD;
                        dirRightD = hitL;
                        if (hitCntQ == HIT_LAST) begin
                            hitCntD = '0;
                            if (speedQ < SPD_MAX) begin
                                speedD = speedQ + 4'd1;
                            end
                        end else begin
                            hitCntD = hitCntQ + 1'b1;
                        end
                    end else if ((nx - RAD <= WALL_LFT) || (nx + RAD >= WALL_RGT)) begin
                        nx        = X_MID;
                        ny        = Y_MID;
                        speedD    = SPD_INIT;
                        hitCntD   = '0;
                        serveCntD = '0;
                        if (xCur < X_MID) begin
                            scoreRD   = scoreRQ + 4'd1;
                            pointRD   = 1'b1;
                            dirRightD = 1'b0;
                            winnerD   = 1'b1;
                            stateD    = (scoreRQ + 4'd1 == WIN) ? StGameOver : StServe;
                        end else begin
                            scoreLD   = scoreLQ + 4'd1;
                            pointLD   = 1'b1;
                            dirRightD = 1'b1;
                            winnerD   = 1'b0;
                            stateD    = (scoreLQ + 4'd1 == WIN) ? StGameOver : StServe;
                        end
                    end
                    xBallD = 11'(nx);
                    yBallD = 11'(ny);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tickCntQ  <= '0;
            stateQ    <= StIdle;
            xBallQ    <= 11'(X_MID);
            yBallQ    <= 11'(Y_MID);
            yPLQ      <= 11'(PAD_INIT);
            yPRQ      <= 11'(PAD_INIT);
            dirRightQ <= 1'b1;
            dirDownQ  <= 1'b1;
            speedQ    <= SPD_INIT;
            hitCntQ   <= '0;
            serveCntQ <= '0;
            scoreLQ   <= '0;
            scoreRQ   <= '0;
            winnerQ   <= 1'b0;
            pointLQ   <= 1'b0;
            pointRQ   <= 1'b0;
        end else begin
            tickCntQ  <= (tickCntQ == TICK_LAST) ? '0 : tickCntQ + 1'b1;
            stateQ    <= stateD;
            xBallQ    <= xBallD;
            yBallQ    <= yBallD;
            yPLQ      <= yPLD;
            yPRQ      <= yPRD;
            dirRightQ <= dirRightD;
            dirDownQ  <= dirDownD;
            speedQ    <= speedD;
            hitCntQ   <= hitCntD;
            serveCntQ <= serveCntD;
            scoreLQ   <= scoreLD;
            scoreRQ   <= scoreRD;
            winnerQ   <= winnerD;
            pointLQ   <= pointLD;
            pointRQ   <= pointRD;
        end
    end

    assign xBall    = xBallQ;
    assign yBall    = yBallQ;
    assign yPL      = yPLQ;
    assign yPR      = yPRQ;
    assign scoreL   = scoreLQ;
    assign scoreR   = scoreRQ;
    assign state    = stateQ;
    assign gameOver = (stateQ == StGameOver);
    assign winner   = winnerQ;
    assign pointL   = pointLQ;
    assign pointR   = pointRQ;

endmodule
